// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared FPU definitions: single-precision field widths, the layout of the
// extended adder sum {carry, hidden, fraction, G, R, S}, the normalizer state
// encoding and the operand magnitude-compare codes used by the pre-add aligner.
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int MANTISSA_WIDTH = 23;
  localparam int EXP_WIDTH      = 8;
  localparam int EXP_MAX        = (1 << EXP_WIDTH) - 1;
  localparam int BIAS           = (1 << (EXP_WIDTH - 1)) - 1;

  // Bit positions inside the extended sum for the default single-precision width.
  localparam int SUM_WIDTH  = MANTISSA_WIDTH + 5;
  localparam int CARRY_BIT  = MANTISSA_WIDTH + 4;
  localparam int HIDDEN_BIT = MANTISSA_WIDTH + 3;
  // The guard/round/sticky tail and the mantissa LSB sit at fixed positions
  // regardless of mantissa width.
  localparam int LSB_BIT    = 3;
  localparam int G_BIT      = 2;
  localparam int R_BIT      = 1;
  localparam int S_BIT      = 0;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } norm_state_e;

  typedef enum logic [1:0] {
    AGREATER,
    BGREATER,
    EQUAL
  } mag_cmp_e;

endpackage

// File: rtl/fpu_rne_rounder.sv
// -----------------------------------------------------------------------------
// fpu_rne_rounder
// Combinational round-to-nearest-even of a mantissa (hidden bit included)
// using its guard/round/sticky tail. Shared by the adder and multiplier paths.
//   i_mant   mantissa with hidden bit, LSB is the rounding position
//   i_grs    {guard, round, sticky}
//   o_mant   rounded mantissa (wraps to zero when the increment carries out)
//   o_carry  increment carried out of the top bit; caller bumps its exponent
// -----------------------------------------------------------------------------
module fpu_rne_rounder #(
  parameter int MW = 24
) (
  input  logic [MW-1:0] i_mant,
  input  logic [2:0]    i_grs,
  output logic [MW-1:0] o_mant,
  output logic          o_carry
);

  logic w_round_up;

  // Round up above the halfway point, or exactly at it when the LSB is odd.
  assign w_round_up = i_grs[2] & (i_grs[1] | i_grs[0] | i_mant[0]);

  assign {o_carry, o_mant} = {1'b0, i_mant} + {{MW{1'b0}}, w_round_up};

endmodule

// File: rtl/mantissa_normalizer.sv
// -----------------------------------------------------------------------------
// mantissa_normalizer
// Normalizes the raw mantissa-adder sum back to 1.xxx form, adjusts the
// exponent, rounds RNE and packs an IEEE-754 result. Iterative: one shift
// decision per cycle, one operation in flight.
//   clk, arst_n           clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready only while idle)
//   sum_in                {carry, hidden, fraction, G, R, S}
//   exp_in, sign_in       biased exponent of the larger operand, result sign
//   out_valid / out_ready output handshake; result and flags held until taken
//   result                {sign, exp, fraction}
//   overflow              result forced to infinity
//   underflow             result flushed to signed zero
//   zero                  sum was exactly zero
// -----------------------------------------------------------------------------
module mantissa_normalizer #(
  parameter int MANTISSA_WIDTH = fpu_pkg::MANTISSA_WIDTH,
  parameter int EXP_WIDTH      = fpu_pkg::EXP_WIDTH
) (
  input  logic                                clk,
  input  logic                                arst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [MANTISSA_WIDTH+4:0]           sum_in,
  input  logic [EXP_WIDTH-1:0]                exp_in,
  input  logic                                sign_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   result,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                zero
);

  import fpu_pkg::*;

  localparam int SUM_W      = MANTISSA_WIDTH + 5;
  localparam int CARRY_POS  = MANTISSA_WIDTH + 4;
  localparam int HIDDEN_POS = MANTISSA_WIDTH + 3;
  localparam int RES_W      = EXP_WIDTH + MANTISSA_WIDTH + 1;

  // One extra exponent bit so +1 on a saturated exponent is visible, not wrapped.
  localparam logic [EXP_WIDTH:0] EXP_ONE      = {{EXP_WIDTH{1'b0}}, 1'b1};
  localparam logic [EXP_WIDTH:0] EXP_ALL_ONES = {1'b0, {EXP_WIDTH{1'b1}}};

  norm_state_e              r_state, w_state_nxt;
  logic [SUM_W-1:0]         r_sum, w_sum_nxt;
  logic [EXP_WIDTH:0]       r_exp, w_exp_nxt;
  logic                     r_sign, w_sign_nxt;
  logic [RES_W-1:0]         r_result, w_result_nxt;
  logic                     r_overflow, w_overflow_nxt;
  logic                     r_underflow, w_underflow_nxt;
  logic                     r_zero, w_zero_nxt;

  logic [MANTISSA_WIDTH:0]  w_rnd_mant;
  logic                     w_rnd_carry;
  logic [EXP_WIDTH:0]       w_exp_round;

  fpu_rne_rounder #(
    .MW (MANTISSA_WIDTH + 1)
  ) u_rounder (
    .i_mant  (r_sum[HIDDEN_POS:LSB_BIT]),
    .i_grs   (r_sum[G_BIT:S_BIT]),
    .o_mant  (w_rnd_mant),
    .o_carry (w_rnd_carry)
  );

  assign w_exp_round = r_exp + {{EXP_WIDTH{1'b0}}, w_rnd_carry};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    w_state_nxt     = r_state;
    w_sum_nxt       = r_sum;
    w_exp_nxt       = r_exp;
    w_sign_nxt      = r_sign;
    w_result_nxt    = r_result;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    w_zero_nxt      = r_zero;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sum_nxt       = sum_in;
          w_exp_nxt       = {1'b0, exp_in};
          w_sign_nxt      = sign_in;
          w_result_nxt    = '0;
          w_overflow_nxt  = 1'b0;
          w_underflow_nxt = 1'b0;
          w_zero_nxt      = 1'b0;
          w_state_nxt     = NORM;
        end
      end

      NORM: begin
        if (r_sum == '0) begin
          w_zero_nxt   = 1'b1;
          w_result_nxt = {r_sign, {(RES_W-1){1'b0}}};
          w_state_nxt  = DONE;
        end else if (r_sum[CARRY_POS]) begin
          // Right shift by one: the old R falls into the sticky position and
          // merges with the old sticky, so no set bit is ever lost.
          w_sum_nxt   = {1'b0, r_sum[SUM_W-1:2], r_sum[R_BIT] | r_sum[S_BIT]};
          w_exp_nxt   = r_exp + EXP_ONE;
          w_state_nxt = ROUND;
        end else if (r_sum[HIDDEN_POS]) begin
          w_state_nxt = ROUND;
        end else if (r_exp <= EXP_ONE) begin
          // Shifting further would need a denormal exponent; flush instead.
          w_underflow_nxt = 1'b1;
          w_result_nxt    = {r_sign, {(RES_W-1){1'b0}}};
          w_state_nxt     = DONE;
        end else begin
          // Left shift by one; the sticky bit keeps its value rather than
          // being refilled with zero.
          w_sum_nxt = {r_sum[SUM_W-2:0], r_sum[S_BIT]};
          w_exp_nxt = r_exp - EXP_ONE;
        end
      end

      ROUND: begin
        if (w_exp_round >= EXP_ALL_ONES) begin
          w_overflow_nxt = 1'b1;
          w_result_nxt   = {r_sign, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
        end else begin
          // On a rounding carry-out the rounded mantissa is already all zeros.
          w_result_nxt = {r_sign, w_exp_round[EXP_WIDTH-1:0],
                          w_rnd_mant[MANTISSA_WIDTH-1:0]};
        end
        w_state_nxt = DONE;
      end

      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sum       <= w_sum_nxt;
      r_exp       <= w_exp_nxt;
      r_sign      <= w_sign_nxt;
      r_result    <= w_result_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
      r_zero      <= w_zero_nxt;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_mantissa_normalizer.sv
module tb_mantissa_normalizer;

  logic        clk;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] sum_in;
  logic [7:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        zero;

  int total = 0;
  int bad   = 0;

  mantissa_normalizer dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] sum;
    logic [7:0]  exp;
    logic        sign;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        zro;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Handshake one input and wait for out_valid; lat counts edges from the
  // handshake edge (T+1) so out_valid seen after it gives latency T+lat.
  task automatic run_op(input logic [27:0] s, input logic [7:0] e, input logic sg,
                        output int lat);
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    sum_in   = s;
    exp_in   = e;
    sign_in  = sg;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (lat <= 100) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    if (!out_valid) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("retire_out_valid", {31'd0, out_valid}, 32'd0);
    check("retire_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int          lat;
    logic [31:0] held;

    vecs[0]  = '{28'h8000000, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 3};  // 2.0 via carry
    vecs[1]  = '{28'h0000008, 8'd127, 1'b0, 32'h34000000, 1'b0, 1'b0, 1'b0, 26}; // 23 left shifts
    vecs[2]  = '{28'h0000008, 8'd10,  1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 11}; // underflow flush
    vecs[3]  = '{28'h7FFFFFC, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 3};  // tie, lsb=1, carry
    vecs[4]  = '{28'h4000004, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 3};  // tie, lsb=0
    vecs[5]  = '{28'h8000000, 8'd254, 1'b1, 32'hFF800000, 1'b1, 1'b0, 1'b0, 3};  // carry overflow
    vecs[6]  = '{28'h0000000, 8'd127, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 2};  // exact zero
    vecs[7]  = '{28'hC000006, 8'd127, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 3};  // 3.0, R|S merged
    vecs[8]  = '{28'h4000006, 8'd127, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b0, 3};  // above half
    vecs[9]  = '{28'h2000000, 8'd127, 1'b0, 32'h3F000000, 1'b0, 1'b0, 1'b0, 4};  // one left shift
    vecs[10] = '{28'h7FFFFFC, 8'd254, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, 3};  // round into inf
    vecs[11] = '{28'h2000000, 8'd1,   1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 2};  // exp<=1 at once

    arst_n    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    exp_in    = '0;
    sign_in   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, overflow, underflow, zero}, 32'd0);
    arst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sum, vecs[i].exp, vecs[i].sign, lat);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_flags", i), {29'd0, overflow, underflow, zero},
            {29'd0, vecs[i].ovf, vecs[i].unf, vecs[i].zro});
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy", i), {31'd0, in_ready}, 32'd0);
      accept();
    end

    // Backpressure: output held for 5 cycles, retired on the 6th.
    run_op(28'h8000000, 8'd254, 1'b1, lat);
    held = result;
    check("bp_first_result", held, 32'hFF800000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_result", result, held);
      check("bp_overflow", {31'd0, overflow}, 32'd1);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    accept();

    // Reset in the middle of a long normalization abandons it.
    @(negedge clk);
    sum_in   = 28'h0000008;
    exp_in   = 8'd127;
    sign_in  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    arst_n = 1'b1;
    run_op(28'h8000000, 8'd127, 1'b0, lat);
    check("postrst_result", result, 32'h40000000);
    check("postrst_latency", lat, 32'd3);
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
